// File: rtl/shift_reg_seq.sv
// shift_reg_seq: multi-cycle shifter/rotator (LSL, LSR, ASR, ROL, ROR) that
// moves up to STEP bits per clock, with valid/ready handshakes on both sides.
//
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   in_valid_i, in_ready_o   operand handshake (ready only in IDLE)
//   din_i, amt_i, mode_i     operand, shift amount, mode (sampled at accept)
//   abort_i                  cancel the operation in SHIFT or DONE
//   out_valid_o, out_ready_i result handshake (valid only in DONE)
//   dout_o                   working/result register
//   busy_o                   high in SHIFT or DONE
//   carry_o                  last bit shifted out (SHIFT_REG_SEQ_CARRY_EN only)
//
// Optional feature macro: SHIFT_REG_SEQ_CARRY_EN adds carry_o.

module shift_reg_seq #(
    parameter int SIZE  = 8,
    parameter int STEP  = 1,
    parameter int AMT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [SIZE-1:0]  din_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [2:0]       mode_i,
    input  logic             abort_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [SIZE-1:0]  dout_o,
    output logic             busy_o
`ifdef SHIFT_REG_SEQ_CARRY_EN
    ,
    output logic             carry_o
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    logic [1:0]       state_q;
    logic [SIZE-1:0]  dout_q;
    logic [AMT_W-1:0] rem_q;
    logic [2:0]       mode_q;

    logic [AMT_W-1:0] k;
    logic [AMT_W-1:0] rem_nxt;
    logic [SIZE-1:0]  step_d;

`ifdef SHIFT_REG_SEQ_CARRY_EN
    logic carry_q;
    logic step_c;
`endif

    // k = min(STEP, rem). When STEP exceeds the largest encodable amount
    // the comparison always picks rem, so the cast below never truncates.
    always_comb begin
        if (32'(rem_q) > STEP) begin
            k = AMT_W'(STEP);
        end else begin
            k = rem_q;
        end
        rem_nxt = rem_q - k;
    end

    // A k-bit step is built from k single-bit steps so the carry naturally
    // ends up as the last bit that left the word (or wrapped around).
    always_comb begin
        step_d = dout_q;
`ifdef SHIFT_REG_SEQ_CARRY_EN
        step_c = carry_q;
`endif
        for (int i = 0; i < STEP; i++) begin
            if (32'(i) < 32'(k)) begin
`ifdef SHIFT_REG_SEQ_CARRY_EN
                if (mode_q == MODE_LSL || mode_q == MODE_ROL) begin
                    step_c = step_d[SIZE-1];
                end else begin
                    step_c = step_d[0];
                end
`endif
                case (mode_q)
                    MODE_LSL: step_d = {step_d[SIZE-2:0], 1'b0};
                    MODE_LSR: step_d = {1'b0, step_d[SIZE-1:1]};
                    MODE_ASR: step_d = {step_d[SIZE-1], step_d[SIZE-1:1]};
                    MODE_ROL: step_d = {step_d[SIZE-2:0], step_d[SIZE-1]};
                    MODE_ROR: step_d = {step_d[0], step_d[SIZE-1:1]};
                    default:  step_d = step_d;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            dout_q  <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_LSL;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // abort_i has no effect here; the operand is still taken
                    if (in_valid_i) begin
                        dout_q <= din_i;
                        rem_q  <= amt_i;
                        mode_q <= mode_i;
                        if (amt_i == '0 || mode_i > MODE_ROR) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        rem_q   <= '0;
                    end else begin
                        dout_q <= step_d;
                        rem_q  <= rem_nxt;
                        if (rem_nxt == '0) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        rem_q   <= '0;
                    end else if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_REG_SEQ_CARRY_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            carry_q <= 1'b0;
        end else if (state_q == IDLE && in_valid_i) begin
            carry_q <= 1'b0;
        end else if (state_q == SHIFT && !abort_i) begin
            carry_q <= step_c;
        end
    end

    assign carry_o = carry_q;
`endif

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == SHIFT) || (state_q == DONE);
    assign dout_o      = dout_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: directed bench for shift_reg_seq, STEP=1 and STEP=3
// instances, with hand-computed results, latencies and carries.

module tb_shift_reg_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       a_in_valid = 1'b0;
    logic       a_abort = 1'b0;
    logic       a_out_ready = 1'b0;
    logic [7:0] a_din = 8'h00;
    logic [3:0] a_amt = 4'h0;
    logic [2:0] a_mode = 3'b000;
    logic       a_in_ready, a_out_valid, a_busy;
    logic [7:0] a_dout;

    logic       b_in_valid = 1'b0;
    logic       b_abort = 1'b0;
    logic       b_out_ready = 1'b0;
    logic [7:0] b_din = 8'h00;
    logic [3:0] b_amt = 4'h0;
    logic [2:0] b_mode = 3'b000;
    logic       b_in_ready, b_out_valid, b_busy;
    logic [7:0] b_dout;

`ifdef SHIFT_REG_SEQ_CARRY_EN
    logic a_carry, b_carry;
`endif

    shift_reg_seq #(.SIZE(8), .STEP(1), .AMT_W(4)) u_a (
        .clk_i      (clk),
        .reset_ni   (rst_n),
        .in_valid_i (a_in_valid),
        .in_ready_o (a_in_ready),
        .din_i      (a_din),
        .amt_i      (a_amt),
        .mode_i     (a_mode),
        .abort_i    (a_abort),
        .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready),
        .dout_o     (a_dout),
        .busy_o     (a_busy)
`ifdef SHIFT_REG_SEQ_CARRY_EN
        ,
        .carry_o    (a_carry)
`endif
    );

    shift_reg_seq #(.SIZE(8), .STEP(3), .AMT_W(4)) u_b (
        .clk_i      (clk),
        .reset_ni   (rst_n),
        .in_valid_i (b_in_valid),
        .in_ready_o (b_in_ready),
        .din_i      (b_din),
        .amt_i      (b_amt),
        .mode_i     (b_mode),
        .abort_i    (b_abort),
        .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready),
        .dout_o     (b_dout),
        .busy_o     (b_busy)
`ifdef SHIFT_REG_SEQ_CARRY_EN
        ,
        .carry_o    (b_carry)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_a(input string tag, input logic [7:0] d,
                         input logic [3:0] amt, input logic [2:0] mode,
                         input int lat_exp, input logic [7:0] d_exp,
                         input logic c_exp);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_din = d;
        a_amt = amt;
        a_mode = mode;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_din = ~d;
        a_amt = ~amt;
        a_mode = 3'b001;
        lat = 0;
        busy_ok = 1'b1;
        while (!a_out_valid && lat < 40) begin
            if (!a_busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!a_busy) busy_ok = 1'b0;
        check({tag, ".lat"}, lat, lat_exp);
        check({tag, ".dout"}, a_dout, d_exp);
        check({tag, ".busy"}, busy_ok, 1);
`ifdef SHIFT_REG_SEQ_CARRY_EN
        check({tag, ".carry"}, a_carry, c_exp);
`endif
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check({tag, ".idle"}, {a_in_ready, a_out_valid}, 2'b10);
    endtask

    task automatic run_b(input string tag, input logic [7:0] d,
                         input logic [3:0] amt, input logic [2:0] mode,
                         input int lat_exp, input logic [7:0] d_exp,
                         input logic c_exp);
        int lat;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_din = d;
        b_amt = amt;
        b_mode = mode;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_din = ~d;
        b_amt = ~amt;
        lat = 0;
        while (!b_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, lat_exp);
        check({tag, ".dout"}, b_dout, d_exp);
`ifdef SHIFT_REG_SEQ_CARRY_EN
        check({tag, ".carry"}, b_carry, c_exp);
`endif
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check({tag, ".idle"}, {b_in_ready, b_out_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        repeat (2) @(negedge clk);
        check("rst.flags", {a_in_ready, a_out_valid, a_busy}, 3'b100);
        check("rst.dout", a_dout, 8'h00);
`ifdef SHIFT_REG_SEQ_CARRY_EN
        check("rst.carry", a_carry, 1'b0);
`endif
        rst_n = 1'b1;

        run_a("lsl1",   8'h81, 4'd1,  3'b000, 1,  8'h02, 1'b1);
        run_a("asr3",   8'h90, 4'd3,  3'b010, 3,  8'hF2, 1'b0);
        run_a("ror9",   8'h01, 4'd9,  3'b100, 9,  8'h80, 1'b1);
        run_a("lsr10",  8'hFF, 4'd10, 3'b001, 10, 8'h00, 1'b0);
        run_a("rol12",  8'hB4, 4'd12, 3'b011, 12, 8'h4B, 1'b1);
        run_a("asr15",  8'h80, 4'd15, 3'b010, 15, 8'hFF, 1'b1);
        run_a("amt0",   8'h5A, 4'd0,  3'b000, 0,  8'h5A, 1'b0);
        run_a("rsvd",   8'h33, 4'd5,  3'b101, 0,  8'h33, 1'b0);
        run_a("lsl7",   8'h01, 4'd7,  3'b000, 7,  8'h80, 1'b0);

        // backpressure in DONE, with competing operands that must be ignored
        @(negedge clk);
        a_in_valid = 1'b1;
        a_din = 8'hF0;
        a_amt = 4'd2;
        a_mode = 3'b001;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp.valid", a_out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_din = 8'hAA;
            a_amt = 4'd1;
            a_mode = 3'b000;
            @(negedge clk);
            check("bp.hold", {a_out_valid, a_in_ready, a_dout},
                  {1'b1, 1'b0, 8'h3C});
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check("bp.release", {a_in_ready, a_out_valid, a_busy}, 3'b100);
        check("bp.dout", a_dout, 8'h3C);

        // abort on the second SHIFT cycle of a 6-bit LSL
        @(negedge clk);
        a_in_valid = 1'b1;
        a_din = 8'h03;
        a_amt = 4'd6;
        a_mode = 3'b000;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        check("abort.flags", {a_in_ready, a_out_valid, a_busy}, 3'b100);
        check("abort.dout", a_dout, 8'h06);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        check("abort.novalid", seen, 1'b0);

        // abort while IDLE must not block acceptance
        @(negedge clk);
        a_in_valid = 1'b1;
        a_abort = 1'b1;
        a_din = 8'h81;
        a_amt = 4'd1;
        a_mode = 3'b000;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_abort = 1'b0;
        check("idleabort.busy", a_busy, 1'b1);
        @(negedge clk);
        check("idleabort.res", {a_out_valid, a_dout}, {1'b1, 8'h02});
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;

        run_b("s3lsr7", 8'hFF, 4'd7, 3'b001, 3, 8'h01, 1'b1);
        run_b("s3lsl8", 8'h01, 4'd8, 3'b000, 3, 8'h00, 1'b1);
        run_b("s3ror4", 8'h0F, 4'd4, 3'b100, 2, 8'hF0, 1'b1);

        // asynchronous reset in the middle of SHIFT, away from any edge
        @(negedge clk);
        a_in_valid = 1'b1;
        a_din = 8'h55;
        a_amt = 4'd9;
        a_mode = 3'b100;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("arst.pre", a_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.flags", {a_in_ready, a_out_valid, a_busy}, 3'b100);
        check("arst.dout", a_dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        check("arst.novalid", seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
